// File: rtl/sd_card_dat.sv
// SD card-side DAT line engine: transmits read blocks and receives write blocks
// on a 1- or 4-bit bus with per-lane CRC16, CRC status token and busy signalling.
module sd_card_dat (
   input  logic        sdclk_i,
   input  logic        rst_dat_ni,
   input  logic        start_read_i,
   input  logic        start_write_i,
   input  logic        dat_width_i,
   input  logic [11:0] block_size_i,
   input  logic [7:0]  busy_cycles_i,
   input  logic [7:0]  tx_data_i,
   output logic        tx_ready_o,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   output logic        done_o,
   output logic        crc_error_o,
   output logic        end_bit_error_o,
   input  logic [3:0]  dat_i,
   output logic [3:0]  dat_o,
   output logic [3:0]  dat_t
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_RD_WAIT   = 4'd1;
   localparam logic [3:0] S_RD_START  = 4'd2;
   localparam logic [3:0] S_RD_DATA   = 4'd3;
   localparam logic [3:0] S_RD_CRC    = 4'd4;
   localparam logic [3:0] S_RD_END    = 4'd5;
   localparam logic [3:0] S_WR_WAIT   = 4'd6;
   localparam logic [3:0] S_WR_DATA   = 4'd7;
   localparam logic [3:0] S_WR_CRC    = 4'd8;
   localparam logic [3:0] S_WR_END    = 4'd9;
   localparam logic [3:0] S_WR_GAP    = 4'd10;
   localparam logic [3:0] S_WR_STATUS = 4'd11;
   localparam logic [3:0] S_WR_BUSY   = 4'd12;

   logic [3:0]  r_state;
   logic        r_width;
   logic [11:0] r_block_size;
   logic [7:0]  r_busy_cycles;
   logic [11:0] r_byte_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_cnt;
   logic [7:0]  r_shift;
   logic [15:0] r_crc [4];
   logic        r_crc_err;
   logic        r_end_err;
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;
   logic        r_done;

   logic [3:0]  w_lane_mask;
   logic        w_byte_last;
   logic        w_block_last;
   logic [3:0]  w_rd_bits;
   logic [3:0]  w_crc_msb;
   logic [7:0]  w_shift_in;
   logic        w_status_bit;

   function automatic logic [15:0] f_crc_step(input logic [15:0] crc, input logic bit_in);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? 16'h1021 : 16'h0000);
   endfunction

   assign w_lane_mask  = r_width ? 4'hF : 4'h1;
   assign w_byte_last  = r_width ? r_bit_cnt[0] : (r_bit_cnt == 3'd7);
   // A block_size of 0 wraps the 12-bit compare, giving a 4096-byte block.
   assign w_block_last = ((r_byte_cnt + 12'd1) == r_block_size);
   assign w_rd_bits    = r_width ? r_shift[7:4] : {3'b111, r_shift[7]};
   assign w_crc_msb    = {r_crc[3][15], r_crc[2][15], r_crc[1][15], r_crc[0][15]};
   assign w_shift_in   = r_width ? {r_shift[3:0], dat_i} : {r_shift[6:0], dat_i[0]};

   // Status frame: start 0, token (good 010 / bad 101), end 1.
   always_comb begin
      case (r_cnt[2:0])
         3'd0:    w_status_bit = 1'b0;
         3'd1:    w_status_bit = r_crc_err;
         3'd2:    w_status_bit = ~r_crc_err;
         3'd3:    w_status_bit = r_crc_err;
         default: w_status_bit = 1'b1;
      endcase
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      dat_t      = 4'hF;
      dat_o      = 4'hF;
      tx_ready_o = 1'b0;
      case (r_state)
         S_RD_START: begin
            dat_t      = ~w_lane_mask;
            dat_o      = ~w_lane_mask;
            tx_ready_o = 1'b1;
         end
         S_RD_DATA: begin
            dat_t      = ~w_lane_mask;
            dat_o      = w_rd_bits;
            tx_ready_o = w_byte_last & ~w_block_last;
         end
         S_RD_CRC: begin
            dat_t = ~w_lane_mask;
            dat_o = r_width ? w_crc_msb : {3'b111, w_crc_msb[0]};
         end
         S_RD_END: dat_t = ~w_lane_mask;
         S_WR_STATUS: begin
            dat_t = 4'b1110;
            dat_o = {3'b111, w_status_bit};
         end
         S_WR_BUSY: begin
            dat_t = 4'b1110;
            dat_o = 4'b1110;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sdclk_i or negedge rst_dat_ni) begin
      if (!rst_dat_ni) begin
         r_state       <= S_IDLE;
         r_width       <= 1'b0;
         r_block_size  <= '0;
         r_busy_cycles <= '0;
         r_byte_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_cnt         <= '0;
         r_shift       <= '0;
         // NOTE: the CRC array is tiny flop storage, not RAM, so it takes the reset too.
         for (int i = 0; i < 4; i++) r_crc[i] <= '0;
         r_crc_err     <= 1'b0;
         r_end_err     <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every register sees pre-edge values.
         r_done     <= 1'b0;
         r_rx_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_read_i || start_write_i) begin
                  r_width       <= dat_width_i;
                  r_block_size  <= block_size_i;
                  r_busy_cycles <= busy_cycles_i;
                  r_byte_cnt    <= '0;
                  r_bit_cnt     <= '0;
                  r_cnt         <= '0;
                  r_crc_err     <= 1'b0;
                  r_end_err     <= 1'b0;
                  for (int i = 0; i < 4; i++) r_crc[i] <= '0;
                  r_state       <= start_read_i ? S_RD_WAIT : S_WR_WAIT;
               end
            end
            S_RD_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd1) begin
                  r_cnt   <= '0;
                  r_state <= S_RD_START;
               end
            end
            S_RD_START: begin
               r_shift   <= tx_data_i;
               r_bit_cnt <= '0;
               r_state   <= S_RD_DATA;
            end
            S_RD_DATA: begin
               for (int i = 0; i < 4; i++) r_crc[i] <= f_crc_step(r_crc[i], w_rd_bits[i]);
               r_shift   <= r_width ? {r_shift[3:0], 4'h0} : {r_shift[6:0], 1'b0};
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_last) begin
                  r_bit_cnt  <= '0;
                  r_byte_cnt <= r_byte_cnt + 12'd1;
                  if (w_block_last) begin
                     r_cnt   <= '0;
                     r_state <= S_RD_CRC;
                  end else begin
                     r_shift <= tx_data_i;
                  end
               end
            end
            S_RD_CRC: begin
               for (int i = 0; i < 4; i++) r_crc[i] <= {r_crc[i][14:0], 1'b0};
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd15) r_state <= S_RD_END;
            end
            S_RD_END: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            S_WR_WAIT: begin
               if (!dat_i[0]) begin
                  r_bit_cnt <= '0;
                  r_state   <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               for (int i = 0; i < 4; i++) r_crc[i] <= f_crc_step(r_crc[i], dat_i[i]);
               r_shift   <= w_shift_in;
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (w_byte_last) begin
                  r_bit_cnt  <= '0;
                  r_rx_data  <= w_shift_in;
                  r_rx_valid <= 1'b1;
                  r_byte_cnt <= r_byte_cnt + 12'd1;
                  if (w_block_last) begin
                     r_cnt   <= '0;
                     r_state <= S_WR_CRC;
                  end
               end
            end
            S_WR_CRC: begin
               if (|((dat_i ^ w_crc_msb) & w_lane_mask)) r_crc_err <= 1'b1;
               for (int i = 0; i < 4; i++) r_crc[i] <= {r_crc[i][14:0], 1'b0};
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd15) r_state <= S_WR_END;
            end
            S_WR_END: begin
               if (|(~dat_i & w_lane_mask)) r_end_err <= 1'b1;
               r_cnt   <= '0;
               r_state <= S_WR_GAP;
            end
            S_WR_GAP: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd1) begin
                  r_cnt   <= '0;
                  r_state <= S_WR_STATUS;
               end
            end
            S_WR_STATUS: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'd4) begin
                  r_cnt <= '0;
                  if (r_busy_cycles == 8'd0 || r_crc_err) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WR_BUSY;
                  end
               end
            end
            S_WR_BUSY: begin
               r_cnt <= r_cnt + 8'd1;
               if ((r_cnt + 8'd1) == r_busy_cycles) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_data_o       = r_rx_data;
   assign rx_valid_o      = r_rx_valid;
   assign done_o          = r_done;
   assign crc_error_o     = r_crc_err;
   assign end_bit_error_o = r_end_err;

endmodule

// File: tb/tb_sd_card_dat.sv
// Scoreboard bench for sd_card_dat: expected bus cycles and received bytes are
// queued as stimulus is built, then popped as the DUT drives the bus or strobes rx.
module tb_sd_card_dat;

   logic        sdclk_i = 1'b0;
   logic        rst_dat_ni;
   logic        start_read_i, start_write_i, dat_width_i;
   logic [11:0] block_size_i;
   logic [7:0]  busy_cycles_i, tx_data_i;
   logic        tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o, done_o, crc_error_o, end_bit_error_o;
   logic [3:0]  dat_i, dat_o, dat_t;

   sd_card_dat dut (
      .sdclk_i(sdclk_i), .rst_dat_ni(rst_dat_ni),
      .start_read_i(start_read_i), .start_write_i(start_write_i),
      .dat_width_i(dat_width_i), .block_size_i(block_size_i),
      .busy_cycles_i(busy_cycles_i), .tx_data_i(tx_data_i),
      .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .done_o(done_o), .crc_error_o(crc_error_o), .end_bit_error_o(end_bit_error_o),
      .dat_i(dat_i), .dat_o(dat_o), .dat_t(dat_t)
   );

   always #5 sdclk_i = ~sdclk_i;

   typedef struct packed {logic [3:0] t; logic [3:0] o;} bus_t;

   bus_t       exp_bus[$];
   logic [7:0] exp_rx[$];
   logic [3:0] dat_q[$];
   logic [7:0] tx_bytes[$];
   logic [7:0] wr_bytes[$];

   int n_checks = 0, n_fail = 0;
   int tx_idx, tx_pend, tx_cnt, rx_cnt, done_cnt, drv_cnt, rel_gap, seen_drv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
      return c;
   endfunction

   task automatic clear_counts();
      tx_idx = 0; tx_pend = 0; tx_cnt = 0; rx_cnt = 0;
      done_cnt = 0; drv_cnt = 0; rel_gap = 0; seen_drv = 0;
   endtask

   // One clock cycle: sample outputs at the falling edge, then drive next inputs.
   task automatic tick();
      bus_t e;
      @(negedge sdclk_i);
      if (dat_t !== 4'hF) begin
         drv_cnt++;
         seen_drv = 1;
         if (exp_bus.size() == 0) check("bus_unexpected", {dat_t, dat_o}, 8'hFF);
         else begin
            e = exp_bus.pop_front();
            check("dat_t", dat_t, e.t);
            check("dat_o", dat_o, e.o);
         end
      end else begin
         if (!seen_drv) rel_gap++;
         check("dat_o_released", dat_o, 4'hF);
      end
      if (rx_valid_o) begin
         rx_cnt++;
         if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
         else check("rx_data", rx_data_o, exp_rx.pop_front());
      end
      if (tx_ready_o) tx_cnt++;
      if (done_o) done_cnt++;
      if (tx_pend) tx_idx++;
      tx_data_i = (tx_idx < tx_bytes.size()) ? tx_bytes[tx_idx] : 8'h00;
      tx_pend   = tx_ready_o;
      dat_i     = (dat_q.size() != 0) ? dat_q.pop_front() : 4'hF;
   endtask

   task automatic wait_done(input string tag);
      for (int c = 0; c < 20000 && done_cnt == 0; c++) tick();
      if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
      tick(); tick();
   endtask

   // Read block of the bytes in tx_bytes; optional simultaneous/mid-block write pulses.
   task automatic do_read(input string tag, input logic w, input logic [11:0] size,
                          input bit both, input bit poke);
      logic [15:0] c[4];
      logic [3:0]  em, v;
      int n;
      n  = tx_bytes.size();
      em = w ? 4'h0 : 4'hE;
      for (int l = 0; l < 4; l++) c[l] = '0;
      exp_bus.push_back({em, em});
      foreach (tx_bytes[b]) begin
         if (w) begin
            for (int h = 1; h >= 0; h--) begin
               v = h ? tx_bytes[b][7:4] : tx_bytes[b][3:0];
               for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], v[l]);
               exp_bus.push_back({em, v});
            end
         end else begin
            for (int k = 7; k >= 0; k--) begin
               c[0] = crc_step(c[0], tx_bytes[b][k]);
               exp_bus.push_back({em, 3'b111, tx_bytes[b][k]});
            end
         end
      end
      for (int k = 15; k >= 0; k--) begin
         v = w ? {c[3][k], c[2][k], c[1][k], c[0][k]} : {3'b111, c[0][k]};
         exp_bus.push_back({em, v});
      end
      exp_bus.push_back({em, 4'hF});

      clear_counts();
      dat_width_i   = w;
      block_size_i  = size;
      tx_data_i     = tx_bytes[0];
      start_read_i  = 1'b1;
      start_write_i = both;
      tick();
      start_read_i  = 1'b0;
      start_write_i = 1'b0;
      for (int c2 = 0; c2 < 20000 && done_cnt == 0; c2++) begin
         start_write_i = (poke && c2 == 5);
         tick();
      end
      start_write_i = 1'b0;
      if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
      tick(); tick();
      check({tag, "_gap"}, rel_gap, 2);
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_tx_ready"}, tx_cnt, n);
      check({tag, "_driven"}, drv_cnt, w ? (18 + 2 * n) : (18 + 8 * n));
      check({tag, "_bus_left"}, exp_bus.size(), 0);
   endtask

   // Write block of wr_bytes from the host side, optionally corrupting CRC or end bit.
   task automatic do_write(input string tag, input logic w, input logic [7:0] busy,
                           input bit flip, input bit end_bad);
      logic [15:0] c[4];
      logic [3:0]  v;
      bit          bad;
      int          n;
      n   = wr_bytes.size();
      bad = flip;
      for (int l = 0; l < 4; l++) c[l] = '0;
      repeat (3) dat_q.push_back(4'hF);
      dat_q.push_back(w ? 4'h0 : 4'hE);
      foreach (wr_bytes[b]) begin
         exp_rx.push_back(wr_bytes[b]);
         if (w) begin
            for (int h = 1; h >= 0; h--) begin
               v = h ? wr_bytes[b][7:4] : wr_bytes[b][3:0];
               for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], v[l]);
               dat_q.push_back(v);
            end
         end else begin
            for (int k = 7; k >= 0; k--) begin
               c[0] = crc_step(c[0], wr_bytes[b][k]);
               dat_q.push_back({3'b111, wr_bytes[b][k]});
            end
         end
      end
      for (int k = 15; k >= 0; k--) begin
         v = w ? {c[3][k], c[2][k], c[1][k], c[0][k]} : {3'b111, c[0][k]};
         if (flip && k == 7) v[2] = ~v[2];
         dat_q.push_back(v);
      end
      dat_q.push_back(end_bad ? 4'hE : 4'hF);
      exp_bus.push_back({4'hE, 4'hE});
      exp_bus.push_back({4'hE, 3'b111, bad});
      exp_bus.push_back({4'hE, 3'b111, !bad});
      exp_bus.push_back({4'hE, 3'b111, bad});
      exp_bus.push_back({4'hE, 4'hF});
      if (!bad) repeat (busy) exp_bus.push_back({4'hE, 4'hE});

      clear_counts();
      dat_width_i   = w;
      block_size_i  = n[11:0];
      busy_cycles_i = busy;
      start_write_i = 1'b1;
      tick();
      start_write_i = 1'b0;
      check({tag, "_start_clr_crc"}, crc_error_o, 0);
      check({tag, "_start_clr_end"}, end_bit_error_o, 0);
      wait_done(tag);
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_rx_cnt"}, rx_cnt, n);
      check({tag, "_no_tx_ready"}, tx_cnt, 0);
      check({tag, "_crc_err"}, crc_error_o, bad);
      check({tag, "_end_err"}, end_bit_error_o, end_bad);
      check({tag, "_bus_left"}, exp_bus.size(), 0);
      check({tag, "_rx_left"}, exp_rx.size(), 0);
   endtask

   initial begin
      rst_dat_ni = 1'b0;
      start_read_i = 1'b0; start_write_i = 1'b0; dat_width_i = 1'b0;
      block_size_i = '0; busy_cycles_i = '0; tx_data_i = '0; dat_i = 4'hF;
      clear_counts();
      repeat (3) tick();
      check("rst_dat_t", dat_t, 4'hF);
      check("rst_dat_o", dat_o, 4'hF);
      check("rst_outs", {tx_ready_o, rx_valid_o, done_o, crc_error_o, end_bit_error_o}, 5'b0);
      check("rst_rx_data", rx_data_o, 8'h00);
      rst_dat_ni = 1'b1;
      repeat (2) tick();

      tx_bytes = '{8'hA5, 8'h3C};
      do_read("rd1_size2", 1'b0, 12'd2, 1'b0, 1'b1);

      tx_bytes.delete();
      repeat (512) tx_bytes.push_back(8'hFF);
      do_read("rd4_ff512", 1'b1, 12'd512, 1'b1, 1'b0);

      tx_bytes.delete();
      repeat (4096) tx_bytes.push_back(8'($urandom));
      do_read("rd4_size0", 1'b1, 12'd0, 1'b0, 1'b0);

      wr_bytes = '{8'h12, 8'hAB, 8'hF0, 8'h5E};
      do_write("wr4_good", 1'b1, 8'd10, 1'b0, 1'b0);
      do_write("wr4_crcbad", 1'b1, 8'd10, 1'b1, 1'b0);
      wr_bytes = '{8'h81, 8'h7E, 8'hC3};
      do_write("wr1_nobusy", 1'b0, 8'd0, 1'b0, 1'b0);
      wr_bytes = '{8'h00, 8'hFF, 8'h96, 8'h69};
      do_write("wr4_endbad", 1'b1, 8'd3, 1'b0, 1'b1);

      // Abort a read mid-data with reset, then confirm a fresh read still works.
      tx_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      clear_counts();
      dat_width_i  = 1'b0;
      block_size_i = 12'd4;
      tx_data_i    = tx_bytes[0];
      start_read_i = 1'b1;
      tick();
      start_read_i = 1'b0;
      exp_bus.push_back({4'hE, 4'hE});
      for (int k = 7; k >= 0; k--) exp_bus.push_back({4'hE, 3'b111, tx_bytes[0][k]});
      repeat (10) tick();
      check("pre_rst_driving", dat_t, 4'hE);
      #2 rst_dat_ni = 1'b0;
      #1;
      check("rst_async_dat_t", dat_t, 4'hF);
      check("rst_async_dat_o", dat_o, 4'hF);
      exp_bus.delete();
      repeat (2) tick();
      check("rst_abort_no_done", done_cnt, 0);
      rst_dat_ni = 1'b1;
      tick();
      do_read("rd1_after_rst", 1'b0, 12'd4, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
